// File: rtl/risc_pkg.sv
// Shared load/store definitions: access-size encodings, LSU states,
// fault-cause codes and small decode helpers.
package risc_pkg;

    // Access size as encoded in the RV32I funct3 field
    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_size_t;

    // Load/store unit sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        FAULT  = 2'b11
    } lsu_state_t;

    // Codes reported on dmem_fault_cause
    localparam logic [1:0] CAUSE_MISALIGNED   = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL_SIZE = 2'b01;
    localparam logic [1:0] CAUSE_OUT_OF_RANGE = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT      = 2'b11;

    // Stores only know B/H/W; loads additionally accept the unsigned forms
    function automatic logic sizeLegal(input logic isStore, input logic [2:0] size);
        logic signedOk;
        signedOk = (size == LS_B) || (size == LS_H) || (size == LS_W);
        if (isStore) begin
            return signedOk;
        end
        return signedOk || (size == LS_BU) || (size == LS_HU);
    endfunction

    // True for both halfword encodings
    function automatic logic isHalf(input logic [2:0] size);
        return (size == LS_H) || (size == LS_HU);
    endfunction

    // True for the word encoding
    function automatic logic isWord(input logic [2:0] size);
        return size == LS_W;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables and replicated store data on the
// way out, lane select plus sign/zero extension on the way back.
module lsu_align
    import risc_pkg::*;
(
    input  logic [2:0]  i_stSize,
    input  logic [1:0]  i_stOffset,
    input  logic [31:0] i_stData,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ldSize,
    input  logic [1:0]  i_ldOffset,
    input  logic [31:0] i_ldWord,
    output logic [31:0] o_ldData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: enable the addressed lanes and copy the data into every lane
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_stData;
        case (i_stSize)
            LS_B, LS_BU: begin
                o_be    = 4'b0001 << i_stOffset;
                o_wdata = {4{i_stData[7:0]}};
            end
            LS_H, LS_HU: begin
                o_be    = 4'b0011 << i_stOffset;
                o_wdata = {2{i_stData[15:0]}};
            end
            LS_W: begin
                o_be    = 4'b1111;
                o_wdata = i_stData;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = i_stData;
            end
        endcase
    end

    // Load side: pick the addressed byte or half of the returned word
    always_comb begin
        w_byte = i_ldWord[7:0];
        case (i_ldOffset)
            2'd0: w_byte = i_ldWord[7:0];
            2'd1: w_byte = i_ldWord[15:8];
            2'd2: w_byte = i_ldWord[23:16];
            2'd3: w_byte = i_ldWord[31:24];
            default: w_byte = i_ldWord[7:0];
        endcase
        w_half = i_ldOffset[1] ? i_ldWord[31:16] : i_ldWord[15:0];
    end

    // Load side: extend the selected lane to 32 bits according to the size
    always_comb begin
        o_ldData = i_ldWord;
        case (i_ldSize)
            LS_B:    o_ldData = {{24{w_byte[7]}}, w_byte};
            LS_BU:   o_ldData = {24'd0, w_byte};
            LS_H:    o_ldData = {{16{w_half[15]}}, w_half};
            LS_HU:   o_ldData = {16'd0, w_half};
            default: o_ldData = i_ldWord;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core data port and a req/ack data RAM.
// Checks each access, issues one byte-enabled word request, stalls the core
// until the RAM answers, and reports aborted accesses as one-cycle faults.
module dmem_lsu
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  dmem_req,
    input  logic                  dmem_wr,
    input  logic [2:0]            dmem_size,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_wr_data,
    output logic [31:0]           dmem_rd_data,
    output logic                  dmem_stall,
    output logic                  dmem_fault,
    output logic [1:0]            dmem_fault_cause,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    input  logic                  ram_ack
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_t r_state;
    lsu_state_t w_nextState;

    logic                  r_ramReq;
    logic                  r_ramWe;
    logic [ADDR_WIDTH-3:0] r_ramAddr;
    logic [3:0]            r_ramBe;
    logic [31:0]           r_ramWdata;
    logic [31:0]           r_rdData;
    logic [2:0]            r_size;
    logic [1:0]            r_offset;
    logic [TW-1:0]         r_timer;
    logic                  r_fault;
    logic [1:0]            r_faultCause;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_outOfRange;
    logic                  w_checkFail;
    logic [1:0]            w_checkCause;
    logic                  w_timeoutHit;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ldData;

    // Store lanes come from the live request; load extension uses the
    // size and offset captured when the request was issued.
    lsu_align u_align (
        .i_stSize   (dmem_size),
        .i_stOffset (dmem_addr[1:0]),
        .i_stData   (dmem_wr_data),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .i_ldSize   (r_size),
        .i_ldOffset (r_offset),
        .i_ldWord   (ram_rdata),
        .o_ldData   (w_ldData)
    );

    // Access checks on the incoming request, earliest failing check wins
    always_comb begin
        w_illegal    = !sizeLegal(dmem_wr, dmem_size);
        w_misaligned = (isHalf(dmem_size) && dmem_addr[0])
                    || (isWord(dmem_size) && (dmem_addr[1:0] != 2'b00));
        w_outOfRange = (dmem_addr >> ADDR_WIDTH) != 32'd0;
        w_checkFail  = w_illegal || w_misaligned || w_outOfRange;
        w_checkCause = CAUSE_OUT_OF_RANGE;
        if (w_illegal) begin
            w_checkCause = CAUSE_ILLEGAL_SIZE;
        end else if (w_misaligned) begin
            w_checkCause = CAUSE_MISALIGNED;
        end
    end

    // The timer has seen TIMEOUT_CYC request cycles once it sits at the last count
    assign w_timeoutHit = (r_timer == TW'(TIMEOUT_CYC - 1));

    // Next-state decode; an ack arriving on the last timer cycle still completes
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (dmem_req) begin
                    w_nextState = w_checkFail ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                if (ram_ack) begin
                    w_nextState = DONE;
                end else if (w_timeoutHit) begin
                    w_nextState = FAULT;
                end
            end
            DONE:    w_nextState = IDLE;
            FAULT:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (res_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request fields, timer, load result and fault reporting
    always_ff @(posedge clk) begin
        if (res_n) begin
            r_ramReq     <= 1'b0;
            r_ramWe      <= 1'b0;
            r_ramAddr    <= '0;
            r_ramBe      <= 4'b0000;
            r_ramWdata   <= 32'd0;
            r_rdData     <= 32'd0;
            r_size       <= 3'b000;
            r_offset     <= 2'b00;
            r_timer      <= '0;
            r_fault      <= 1'b0;
            r_faultCause <= 2'b00;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dmem_req) begin
                        if (w_checkFail) begin
                            r_fault      <= 1'b1;
                            r_faultCause <= w_checkCause;
                        end else begin
                            r_ramReq   <= 1'b1;
                            r_ramWe    <= dmem_wr;
                            r_ramAddr  <= dmem_addr[ADDR_WIDTH-1:2];
                            r_ramBe    <= w_be;
                            r_ramWdata <= w_wdata;
                            r_size     <= dmem_size;
                            r_offset   <= dmem_addr[1:0];
                            r_timer    <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (ram_ack) begin
                        r_ramReq <= 1'b0;
                        if (!r_ramWe) begin
                            r_rdData <= w_ldData;
                        end
                    end else if (w_timeoutHit) begin
                        r_ramReq     <= 1'b0;
                        r_fault      <= 1'b1;
                        r_faultCause <= CAUSE_TIMEOUT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The core waits while a request is pending or in flight
    assign dmem_stall       = dmem_req && ((r_state == IDLE) || (r_state == ACCESS));

    assign dmem_rd_data     = r_rdData;
    assign dmem_fault       = r_fault;
    assign dmem_fault_cause = r_faultCause;
    assign ram_req          = r_ramReq;
    assign ram_we           = r_ramWe;
    assign ram_addr         = r_ramAddr;
    assign ram_be           = r_ramBe;
    assign ram_wdata        = r_ramWdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a core-side driver plus a hand-controlled RAM
// ack, with every expected value written out by hand.
module tb_dmem_lsu;

    logic        clk;
    logic        res_n;
    logic        dmem_req;
    logic        dmem_wr;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic [31:0] dmem_rd_data;
    logic        dmem_stall;
    logic        dmem_fault;
    logic [1:0]  dmem_fault_cause;
    logic        ram_req;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    int checkCount;
    int failCount;

    dmem_lsu #(
        .ADDR_WIDTH  (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk              (clk),
        .res_n            (res_n),
        .dmem_req         (dmem_req),
        .dmem_wr          (dmem_wr),
        .dmem_size        (dmem_size),
        .dmem_addr        (dmem_addr),
        .dmem_wr_data     (dmem_wr_data),
        .dmem_rd_data     (dmem_rd_data),
        .dmem_stall       (dmem_stall),
        .dmem_fault       (dmem_fault),
        .dmem_fault_cause (dmem_fault_cause),
        .ram_req          (ram_req),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_be           (ram_be),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .ram_ack          (ram_ack)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something escapes the per-access cycle budgets
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=hang expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present one core request on the next falling edge
    task automatic applyStimulus(input logic wr, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        dmem_req     = 1'b1;
        dmem_wr      = wr;
        dmem_size    = size;
        dmem_addr    = addr;
        dmem_wr_data = wdata;
        ram_ack      = 1'b0;
    endtask

    // Run one access to completion; ackDelay counts ram_req cycles before the
    // ack (0 = ack in the first request cycle, -1 = never acknowledge)
    task automatic runAccess(
        input string       tag,
        input logic        wr,
        input logic [2:0]  size,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] rdata,
        input int          ackDelay,
        input int          expStall,
        input int          expReqCycles,
        input logic        expFault,
        input logic [1:0]  expCause,
        input logic [31:0] expRd,
        input logic [5:0]  expRamAddr,
        input logic [3:0]  expBe,
        input logic [31:0] expWdata
    );
        int          stallCnt;
        int          reqCnt;
        bit          finished;
        logic        seenWe;
        logic [5:0]  seenAddr;
        logic [3:0]  seenBe;
        logic [31:0] seenWdata;
        logic        endFault;
        logic [1:0]  endCause;
        logic [31:0] endRd;
        stallCnt  = 0;
        reqCnt    = 0;
        finished  = 1'b0;
        seenWe    = 1'b0;
        seenAddr  = '0;
        seenBe    = '0;
        seenWdata = '0;
        endFault  = 1'b0;
        endCause  = '0;
        endRd     = '0;
        applyStimulus(wr, size, addr, wdata);
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            #1;
            if (dmem_stall) begin
                stallCnt++;
            end else begin
                finished = 1'b1;
                endFault = dmem_fault;
                endCause = dmem_fault_cause;
                endRd    = dmem_rd_data;
            end
            if (ram_req) begin
                if (reqCnt == 0) begin
                    seenWe    = ram_we;
                    seenAddr  = ram_addr;
                    seenBe    = ram_be;
                    seenWdata = ram_wdata;
                end
                ram_ack   = (reqCnt == ackDelay);
                ram_rdata = rdata;
                reqCnt++;
            end else begin
                ram_ack = 1'b0;
            end
            if (finished) begin
                dmem_req = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        checkOutput({tag, "_completes"}, 32'(finished), 32'd1);
        checkOutput({tag, "_stallCycles"}, 32'(stallCnt), 32'(expStall));
        checkOutput({tag, "_reqCycles"}, 32'(reqCnt), 32'(expReqCycles));
        checkOutput({tag, "_fault"}, 32'(endFault), 32'(expFault));
        if (expFault) begin
            checkOutput({tag, "_cause"}, 32'(endCause), 32'(expCause));
        end
        checkOutput({tag, "_rdData"}, endRd, expRd);
        if (expReqCycles > 0) begin
            checkOutput({tag, "_ramWe"}, 32'(seenWe), 32'(wr));
            checkOutput({tag, "_ramAddr"}, 32'(seenAddr), 32'(expRamAddr));
            checkOutput({tag, "_ramBe"}, 32'(seenBe), 32'(expBe));
            checkOutput({tag, "_ramWdata"}, seenWdata, expWdata);
        end
        @(negedge clk);
        #1;
        checkOutput({tag, "_faultCleared"}, 32'(dmem_fault), 32'd0);
        checkOutput({tag, "_reqIdle"}, 32'(ram_req), 32'd0);
    endtask

    initial begin
        checkCount   = 0;
        failCount    = 0;
        res_n        = 1'b1;
        dmem_req     = 1'b0;
        dmem_wr      = 1'b0;
        dmem_size    = 3'b000;
        dmem_addr    = 32'd0;
        dmem_wr_data = 32'd0;
        ram_rdata    = 32'd0;
        ram_ack      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_ramReq", 32'(ram_req), 32'd0);
        checkOutput("reset_ramWe", 32'(ram_we), 32'd0);
        checkOutput("reset_ramBe", 32'(ram_be), 32'd0);
        checkOutput("reset_ramAddr", 32'(ram_addr), 32'd0);
        checkOutput("reset_ramWdata", ram_wdata, 32'd0);
        checkOutput("reset_rdData", dmem_rd_data, 32'd0);
        checkOutput("reset_fault", 32'(dmem_fault), 32'd0);
        checkOutput("reset_cause", 32'(dmem_fault_cause), 32'd0);
        checkOutput("reset_stall", 32'(dmem_stall), 32'd0);
        res_n = 1'b0;

        //        tag       wr    size    addr          wdata         rdata         ack stall req flt cause  rd            addr  be       wdata
        runAccess("sw10",   1'b1, 3'b010, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 0,  2,    1,  0,  2'b00, 32'h00000000, 6'd4, 4'b1111, 32'hDEADBEEF);
        runAccess("sb13",   1'b1, 3'b000, 32'h00000013, 32'h000000A5, 32'h00000000, 0,  2,    1,  0,  2'b00, 32'h00000000, 6'd4, 4'b1000, 32'hA5A5A5A5);
        runAccess("lb13",   1'b0, 3'b000, 32'h00000013, 32'h00000000, 32'hA5000000, 0,  2,    1,  0,  2'b00, 32'hFFFFFFA5, 6'd4, 4'b1000, 32'h00000000);
        runAccess("lbu13",  1'b0, 3'b100, 32'h00000013, 32'h00000000, 32'hA5000000, 0,  2,    1,  0,  2'b00, 32'h000000A5, 6'd4, 4'b1000, 32'h00000000);
        runAccess("lh12",   1'b0, 3'b001, 32'h00000012, 32'h00000000, 32'h80011234, 0,  2,    1,  0,  2'b00, 32'hFFFF8001, 6'd4, 4'b1100, 32'h00000000);
        runAccess("lhu12",  1'b0, 3'b101, 32'h00000012, 32'h00000000, 32'h80011234, 0,  2,    1,  0,  2'b00, 32'h00008001, 6'd4, 4'b1100, 32'h00000000);
        runAccess("lb01",   1'b0, 3'b000, 32'h00000001, 32'h00000000, 32'h00007F00, 1,  3,    2,  0,  2'b00, 32'h0000007F, 6'd0, 4'b0010, 32'h00000000);
        runAccess("lh10",   1'b0, 3'b001, 32'h00000010, 32'h00000000, 32'h1234C321, 2,  4,    3,  0,  2'b00, 32'hFFFFC321, 6'd4, 4'b0011, 32'h00000000);
        runAccess("lwMis",  1'b0, 3'b010, 32'h00000011, 32'h00000000, 32'h00000000, 0,  1,    0,  1,  2'b00, 32'hFFFFC321, 6'd0, 4'b0000, 32'h00000000);
        runAccess("ldSz3",  1'b0, 3'b011, 32'h00000010, 32'h00000000, 32'h00000000, 0,  1,    0,  1,  2'b01, 32'hFFFFC321, 6'd0, 4'b0000, 32'h00000000);
        runAccess("swOor",  1'b1, 3'b010, 32'h00000100, 32'h11111111, 32'h00000000, 0,  1,    0,  1,  2'b10, 32'hFFFFC321, 6'd0, 4'b0000, 32'h00000000);
        runAccess("stBu",   1'b1, 3'b100, 32'h00000010, 32'h11111111, 32'h00000000, 0,  1,    0,  1,  2'b01, 32'hFFFFC321, 6'd0, 4'b0000, 32'h00000000);
        runAccess("prioSz", 1'b0, 3'b111, 32'h00000101, 32'h00000000, 32'h00000000, 0,  1,    0,  1,  2'b01, 32'hFFFFC321, 6'd0, 4'b0000, 32'h00000000);
        runAccess("prioMis",1'b1, 3'b001, 32'h00000101, 32'h00000000, 32'h00000000, 0,  1,    0,  1,  2'b00, 32'hFFFFC321, 6'd0, 4'b0000, 32'h00000000);
        runAccess("lwTmo",  1'b0, 3'b010, 32'h00000020, 32'h00000000, 32'h00000000, -1, 17,  16,  1,  2'b11, 32'hFFFFC321, 6'd8, 4'b1111, 32'h00000000);
        runAccess("lwAck16",1'b0, 3'b010, 32'h00000024, 32'h00000000, 32'hCAFEF00D, 15, 17,  16,  0,  2'b00, 32'hCAFEF00D, 6'd9, 4'b1111, 32'h00000000);

        // Reset while the RAM request is outstanding, then a late ack
        applyStimulus(1'b0, 3'b010, 32'h00000020, 32'h00000000);
        @(negedge clk);
        #1;
        checkOutput("rst_reqBefore", 32'(ram_req), 32'd1);
        res_n    = 1'b1;
        dmem_req = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_reqDropped", 32'(ram_req), 32'd0);
        checkOutput("rst_rdCleared", dmem_rd_data, 32'd0);
        res_n     = 1'b0;
        ram_ack   = 1'b1;
        ram_rdata = 32'h12345678;
        @(negedge clk);
        ram_ack = 1'b0;
        #1;
        checkOutput("rst_lateAckRd", dmem_rd_data, 32'd0);
        checkOutput("rst_lateAckFault", 32'(dmem_fault), 32'd0);
        checkOutput("rst_lateAckReq", 32'(ram_req), 32'd0);

        runAccess("swPost", 1'b1, 3'b010, 32'h0000003C, 32'h11223344, 32'h00000000, 2,  4,    3,  0,  2'b00, 32'h00000000, 6'd15, 4'b1111, 32'h11223344);
        runAccess("sh3e",   1'b1, 3'b001, 32'h0000003E, 32'h0000BEEF, 32'h00000000, 0,  2,    1,  0,  2'b00, 32'h00000000, 6'd15, 4'b1100, 32'hBEEFBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit that sits directly downstream of the single-cycle core's data-memory port. It is the consumer of `dmem_req`/`dmem_addr`/`dmem_wr_data`.
- Converts byte/half/word loads and stores (RV32I `funct3` encoding) into word-wide, byte-enabled requests to a data RAM. The RAM uses a `req`/`ack` handshake.
- Performs load alignment and sign/zero extension, and stalls the core until the access completes.
- Detects misaligned, illegal-size, out-of-range and timed-out accesses and flags each as a one-cycle fault.

Parameters:
- `ADDR_WIDTH`, 8, byte-address width of the data RAM (RAM holds 2^(`ADDR_WIDTH`-2) words).
- `TIMEOUT_CYC`, 16, maximum cycles `ram_req` waits for `ram_ack` before a fault is raised.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `res_n`  in  1  reset; synchronous, active-high.
- `dmem_req`  in  1  core access request; held stable by the core while `dmem_stall`=1.
- `dmem_wr`  in  1  1=store, 0=load.
- `dmem_size`  in  3  `funct3`: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- `dmem_addr`  in  32  byte address.
- `dmem_wr_data`  in  32  store data, right-aligned.
- `dmem_rd_data`  out  32  extended load data, valid in the DONE cycle.
- `dmem_stall`  out  1  core must hold PC and request.
- `dmem_fault`  out  1  one-cycle pulse, access aborted.
- `dmem_fault_cause`  out  2  00 misaligned, 01 illegal size, 10 out of range, 11 timeout.
- `ram_req`  out  1  RAM request, registered.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  `ADDR_WIDTH`-2  word address.
- `ram_be`  out  4  byte enables.
- `ram_wdata`  out  32  lane-shifted store data.
- `ram_rdata`  in  32  RAM read word, sampled when `ram_ack`=1.
- `ram_ack`  in  1  RAM completion, single-cycle pulse.

Behaviour:

Reset
- On a reset edge, state becomes IDLE. This also applies mid-access.
- Registered outputs reset as follows: `ram_req`, `ram_we`, `dmem_fault` = 0; `ram_be`, `ram_addr`, `ram_wdata`, `dmem_rd_data`, timeout counter, `dmem_fault_cause` = 0.
- An outstanding `ram_ack` that arrives after reset is ignored.

States: IDLE, ACCESS, DONE, FAULT.

IDLE
- Entered when `dmem_req`=1 and the access is checked.
- Checks are evaluated in priority order:
  - illegal size: any store size not 000/001/010, or load size 011/110/111;
  - misaligned: H at `addr[0]`=1, W at `addr[1:0]`!=0;
  - out of range: `addr[31:ADDR_WIDTH]`!=0.
- If any check fails, go to FAULT and never assert `ram_req`.
- Otherwise, next edge:
  - `ram_req`=1;
  - `ram_we`=`dmem_wr`;
  - `ram_addr`=`addr[ADDR_WIDTH-1:2]`;
  - `ram_be` = B: 0001<<`addr[1:0]`; H: 0011<<`addr[1:0]`; W: 1111;
  - `ram_wdata` = store data replicated per lane (B: {4{d[7:0]}}, H: {2{d[15:0]}}, W: d);
  - clear the timer; go to ACCESS.

ACCESS
- `ram_req` and its fields are held constant.
- Timer increments each cycle without ack.
- `ram_ack`=1: capture `ram_rdata`, apply lane select and extension (B/H sign-extend, BU/HU zero-extend; the `addr[1:0]` used is the one registered at issue), drop `ram_req`, go to DONE.
- Timer reaches `TIMEOUT_CYC` with no ack: drop `ram_req`, go to FAULT with cause 11.
- If ack and timeout coincide, ack wins.

DONE (exactly one cycle)
- `dmem_rd_data` is valid and `dmem_stall`=0, so the core retires.
- Return to IDLE. A new `dmem_req` is not accepted in this cycle.

FAULT (one cycle)
- `dmem_fault`=1 with cause; `dmem_stall`=0; return to IDLE.

Stall and latency
- `dmem_stall` = `dmem_req` & (state==IDLE | state==ACCESS). It is combinational.
- Minimum access: request in cycle 0, `ram_req` in cycle 1, ack in cycle 1 → DONE in cycle 2. The core stalls 2 cycles.

Other rules
- `dmem_rd_data` holds its last value outside DONE. For stores it is unchanged.
- `dmem_req` dropping during ACCESS: the access still completes. The result is discarded silently and no fault is raised.

Decomposition:
- Shared package `risc_pkg`:
  - `funct3` size enum: `LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`;
  - `lsu_state_t` enum: IDLE/ACCESS/DONE/FAULT;
  - fault-cause constants.
- Sub-module `lsu_align`: purely combinational. Produces `ram_be` and `ram_wdata` for stores, and performs load lane select plus sign/zero extension. It is instantiated once, and `dmem_lsu` holds the FSM.

Test Plan:
- SW `addr`=0x10, data 0xDEADBEEF, ack after 1 cycle → `ram_addr`=4, `ram_be`=1111, `ram_wdata`=0xDEADBEEF; stall exactly 2 cycles; no fault.
- SB `addr`=0x13, data 0x000000A5 → `ram_be`=1000, `ram_wdata`=0xA5A5A5A5; then LB 0x13 with `ram_rdata`=0xA5000000 → `dmem_rd_data`=0xFFFFFFA5; LBU gives 0x000000A5.
- LH `addr`=0x12 with `ram_rdata`=0x8001_1234 → 0xFFFF8001; LHU → 0x00008001.
- Fault checks, each giving a 1-cycle `dmem_fault`, zero `ram_req`, and stall released:
  - LW 0x11 → cause 00;
  - load `size`=011 → 01;
  - SW 0x100 with `ADDR_WIDTH`=8 → 10.
- LW with `ram_ack` never asserted → `ram_req` high for 16 cycles, then fault cause 11 and `ram_req`=0. Ack coinciding with the 16th cycle → normal completion, no fault.
- Assert `res_n` during ACCESS → next edge `ram_req`=0, state IDLE; a late `ram_ack` produces no `dmem_rd_data` change. A following SW completes normally.
